// File: rtl/dmem_arbiter_pkg.sv
// Shared configuration for the data-RAM arbiter: widths, store-size codes,
// response owner tags and a saturating counter helper.
package dmem_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] NO_STORE = 3'b000;
  localparam logic [2:0] STORE_B  = 3'b001;
  localparam logic [2:0] STORE_H  = 3'b010;
  localparam logic [2:0] STORE_W  = 3'b011;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    if (cnt >= lim) begin
      return lim;
    end else begin
      return cnt + 4'd1;
    end
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Tracks the single load in flight and steers the RAM read word to the
// requester that issued it; the other requester always sees zero.
module dmem_rsp_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_issue_load,
  input  logic            i_issue_owner,
  input  logic [XLEN-1:0] i_ram_rdata,
  output logic            o_cpu_rvalid,
  output logic [XLEN-1:0] o_cpu_rdata,
  output logic            o_dma_rvalid,
  output logic [XLEN-1:0] o_dma_rdata
);
  import dmem_arbiter_pkg::*;

  logic r_rsp_valid;
  logic r_rsp_owner;
  logic w_live;

  // Owner is only overwritten by a real grant, so a dropped request cannot retag it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWN_CPU;
    end else begin
      r_rsp_valid <= i_issue_load;
      r_rsp_owner <= i_issue_load ? i_issue_owner : r_rsp_owner;
    end
  end

  // A response registered just before reset is killed while reset is held.
  always_comb begin
    w_live       = r_rsp_valid & rst_n;
    o_cpu_rvalid = w_live & (r_rsp_owner == OWN_CPU);
    o_dma_rvalid = w_live & (r_rsp_owner == OWN_DMA);
    o_cpu_rdata  = o_cpu_rvalid ? i_ram_rdata : '0;
    o_dma_rdata  = o_dma_rvalid ? i_ram_rdata : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the CPU memory stage and a DMA/debug
// port, with anti-starvation for DMA and locked DMA bursts.
module dmem_arbiter #(
  parameter int XLEN       = dmem_arbiter_pkg::XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [2:0]      cpu_size,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_stall,
  output logic            cpu_rvalid,
  output logic [XLEN-1:0] cpu_rdata,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [2:0]      dma_size,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  input  logic            dma_lock,
  output logic            dma_gnt,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] dma_rdata,
  output logic            ram_en,
  output logic            ram_we,
  output logic [2:0]      ram_size,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata
);
  import dmem_arbiter_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CPU_PRI    = 2'd1,
    ST_DMA_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     r_state;
  logic [3:0] r_starve_cnt;
  logic       w_cpu_gnt;
  logic       w_dma_gnt;
  logic       w_issue_load;
  logic       w_issue_owner;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (!rst_n) begin
      w_cpu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
    end else if (r_state == ST_DMA_LOCKED) begin
      w_dma_gnt = dma_req;
    end else if (cpu_req && dma_req) begin
      if (r_starve_cnt == STARVE_LIM) begin
        w_dma_gnt = 1'b1;
      end else begin
        w_cpu_gnt = 1'b1;
      end
    end else begin
      w_cpu_gnt = cpu_req;
      w_dma_gnt = dma_req;
    end
  end

  // Drive the RAM port from the winner; idle port reads as all zeros.
  always_comb begin
    ram_we    = 1'b0;
    ram_size  = 3'b000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_cpu_gnt) begin
      ram_we    = cpu_we;
      ram_size  = cpu_size;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (w_dma_gnt) begin
      ram_we    = dma_we;
      ram_size  = dma_size;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else begin
      ram_we    = 1'b0;
      ram_size  = 3'b000;
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  assign cpu_gnt       = w_cpu_gnt;
  assign dma_gnt       = w_dma_gnt;
  assign ram_en        = w_cpu_gnt | w_dma_gnt;
  assign cpu_stall     = cpu_req & ~w_cpu_gnt;
  assign w_issue_load  = (w_cpu_gnt & ~cpu_we) | (w_dma_gnt & ~dma_we);
  assign w_issue_owner = w_dma_gnt ? OWN_DMA : OWN_CPU;

  // Ownership FSM and DMA starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      if (!dma_req || w_dma_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (w_cpu_gnt) begin
        r_starve_cnt <= sat_inc(r_starve_cnt, STARVE_LIM);
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end

      if (w_dma_gnt && dma_lock) begin
        r_state <= ST_DMA_LOCKED;
      end else begin
        case (r_state)
          ST_DMA_LOCKED: begin
            if (!dma_lock || !dma_req) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= r_state;
            end
          end
          ST_IDLE, ST_CPU_PRI: begin
            if (w_cpu_gnt && dma_req) begin
              r_state <= ST_CPU_PRI;
            end else if (!cpu_req && !dma_req) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= r_state;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  dmem_rsp_pipe #(
    .XLEN(XLEN)
  ) u_rsp_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_issue_load (w_issue_load),
    .i_issue_owner(w_issue_owner),
    .i_ram_rdata  (ram_rdata),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .o_dma_rvalid (dma_rvalid),
    .o_dma_rdata  (dma_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a behavioural arbitration/response model and a RAM model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [2:0]  cpu_size, dma_size;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] ram_rdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic        ram_en, ram_we;
  logic [2:0]  ram_size;
  logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata;

  dmem_arbiter #(.XLEN(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_size(ram_size), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM model: 256 words, synchronous read with one cycle of latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[9:2]];
    end
  end

  // Staged stimulus, applied just after each rising edge.
  logic        s_rst_n, s_cpu_req, s_cpu_we, s_dma_req, s_dma_we, s_dma_lock;
  logic [2:0]  s_cpu_size, s_dma_size;
  logic [31:0] s_cpu_addr, s_cpu_wdata, s_dma_addr, s_dma_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          m_losses;
  bit          m_burst;
  bit          m_pend;
  bit          m_pend_dma;
  logic [31:0] m_pend_data;

  logic        obs_cg, obs_dg, obs_cs, obs_cv, obs_dv, obs_en, obs_we;
  logic [2:0]  obs_sz;
  logic [31:0] obs_cd, obs_dd, obs_a, obs_w;
  logic        last_e_dg;

  function automatic logic [7:0] widx(input logic [31:0] a);
    return a[9:2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle_stim();
    s_cpu_req = 1'b0; s_cpu_we = 1'b0; s_cpu_size = NO_STORE;
    s_cpu_addr = 32'd0; s_cpu_wdata = 32'd0;
    s_dma_req = 1'b0; s_dma_we = 1'b0; s_dma_size = NO_STORE;
    s_dma_addr = 32'd0; s_dma_wdata = 32'd0; s_dma_lock = 1'b0;
  endtask

  // One clock: apply stimulus, compare all outputs with the model, advance the model.
  task automatic step();
    logic        e_cg, e_dg, e_cv, e_dv, e_we;
    logic [2:0]  e_sz;
    logic [31:0] e_a, e_w, e_cd, e_dd;
    @(posedge clk);
    #1;
    rst_n = s_rst_n; cpu_req = s_cpu_req; cpu_we = s_cpu_we; cpu_size = s_cpu_size;
    cpu_addr = s_cpu_addr; cpu_wdata = s_cpu_wdata; dma_req = s_dma_req; dma_we = s_dma_we;
    dma_size = s_dma_size; dma_addr = s_dma_addr; dma_wdata = s_dma_wdata; dma_lock = s_dma_lock;
    @(negedge clk);
    e_cg = 1'b0; e_dg = 1'b0;
    if (rst_n) begin
      if (m_burst) e_dg = dma_req;
      else if (cpu_req && dma_req) begin
        if (m_losses == SMAX) e_dg = 1'b1;
        else e_cg = 1'b1;
      end else begin
        e_cg = cpu_req; e_dg = dma_req;
      end
    end
    e_we = e_cg ? cpu_we : (e_dg ? dma_we : 1'b0);
    e_sz = e_cg ? cpu_size : (e_dg ? dma_size : 3'b000);
    e_a  = e_cg ? cpu_addr : (e_dg ? dma_addr : 32'd0);
    e_w  = e_cg ? cpu_wdata : (e_dg ? dma_wdata : 32'd0);
    e_cv = rst_n && m_pend && !m_pend_dma;
    e_dv = rst_n && m_pend && m_pend_dma;
    e_cd = e_cv ? m_pend_data : 32'd0;
    e_dd = e_dv ? m_pend_data : 32'd0;
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("dma_gnt", dma_gnt, e_dg);
    chk("cpu_stall", cpu_stall, cpu_req & ~e_cg);
    chk("ram_en", ram_en, e_cg | e_dg);
    chk("ram_we", ram_we, e_we);
    chk("ram_size", ram_size, e_sz);
    chk("ram_addr", ram_addr, e_a);
    chk("ram_wdata", ram_wdata, e_w);
    chk("cpu_rvalid", cpu_rvalid, e_cv);
    chk("dma_rvalid", dma_rvalid, e_dv);
    chk("cpu_rdata", cpu_rdata, e_cd);
    chk("dma_rdata", dma_rdata, e_dd);
    obs_cg = cpu_gnt; obs_dg = dma_gnt; obs_cs = cpu_stall; obs_cv = cpu_rvalid;
    obs_dv = dma_rvalid; obs_en = ram_en; obs_we = ram_we; obs_sz = ram_size;
    obs_cd = cpu_rdata; obs_dd = dma_rdata; obs_a = ram_addr; obs_w = ram_wdata;
    last_e_dg = e_dg;
    if (!rst_n) begin
      m_losses = 0; m_burst = 1'b0; m_pend = 1'b0;
    end else begin
      m_pend = (e_cg && !cpu_we) || (e_dg && !dma_we);
      if (m_pend) begin
        m_pend_dma  = e_dg;
        m_pend_data = mem[widx(e_dg ? dma_addr : cpu_addr)];
      end
      if (!dma_req || e_dg) m_losses = 0;
      else if (e_cg && m_losses < SMAX) m_losses++;
      if (e_dg && dma_lock) m_burst = 1'b1;
      else if (m_burst && (!dma_lock || !dma_req)) m_burst = 1'b0;
    end
    cyc++;
  endtask

  logic [9:0] pat_d, pat_s, pat_m;
  logic [8:0] bur_d, bur_c, bur_s;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= $urandom;
    mem[64]  <= 32'hDEADBEEF;
    mem[128] <= 32'hCAFEF00D;
    mem[129] <= 32'h0BADC0DE;
    m_losses = 0; m_burst = 1'b0; m_pend = 1'b0; m_pend_dma = 1'b0; m_pend_data = 32'd0;
    idle_stim();
    s_rst_n = 1'b0;
    step();
    step();
    chk("rst_cpu_gnt", obs_cg, 1'b0);
    chk("rst_dma_gnt", obs_dg, 1'b0);
    chk("rst_rvalids", {obs_cv, obs_dv}, 2'b00);
    chk("rst_ram_en_we", {obs_en, obs_we}, 2'b00);
    chk("rst_rdata", obs_cd | obs_dd, 32'd0);
    s_rst_n = 1'b1;
    step();

    // CPU-only load
    s_cpu_req = 1'b1; s_cpu_addr = 32'h100;
    step();
    chk("cpu_only_gnt", obs_cg, 1'b1);
    chk("cpu_only_stall0", obs_cs, 1'b0);
    idle_stim();
    step();
    chk("cpu_only_rvalid", obs_cv, 1'b1);
    chk("cpu_only_rdata", obs_cd, 32'hDEADBEEF);
    chk("cpu_only_stall1", obs_cs, 1'b0);

    // Continuous contention
    step();
    for (int c = 0; c < 10; c++) begin
      s_cpu_req = 1'b1; s_cpu_addr = 32'h8; s_dma_req = 1'b1; s_dma_addr = 32'hC;
      step();
      pat_d[c] = obs_dg; pat_s[c] = obs_cs; pat_m[c] = last_e_dg;
    end
    chk("contend_dma_pattern", {22'd0, pat_d}, 32'h210);
    chk("contend_stall_pattern", {22'd0, pat_s}, 32'h210);
    chk("contend_model_pattern", {22'd0, pat_m}, 32'h210);

    // Forced DMA burst of three locked beats while the CPU keeps requesting
    for (int b = 0; b < 9; b++) begin
      s_cpu_req = 1'b1; s_cpu_addr = 32'h10;
      s_dma_req = (b <= 6); s_dma_lock = (b >= 4 && b <= 6); s_dma_addr = 32'h14;
      step();
      bur_d[b] = obs_dg; bur_c[b] = obs_cg; bur_s[b] = obs_cs;
    end
    chk("burst_dma_gnt", {23'd0, bur_d}, 32'h070);
    chk("burst_cpu_gnt", {23'd0, bur_c}, 32'h10F);
    chk("burst_cpu_stall", {23'd0, bur_s}, 32'h0F0);
    idle_stim();
    step();

    // Mixed response routing
    s_cpu_req = 1'b1; s_cpu_addr = 32'h200;
    step();
    idle_stim();
    s_dma_req = 1'b1; s_dma_addr = 32'h204;
    step();
    chk("mix_c1_cpu_rvalid", obs_cv, 1'b1);
    chk("mix_c1_cpu_rdata", obs_cd, 32'hCAFEF00D);
    chk("mix_c1_dma_rvalid", obs_dv, 1'b0);
    chk("mix_c1_dma_rdata", obs_dd, 32'd0);
    idle_stim();
    step();
    chk("mix_c2_dma_rvalid", obs_dv, 1'b1);
    chk("mix_c2_dma_rdata", obs_dd, 32'h0BADC0DE);
    chk("mix_c2_cpu_rvalid", obs_cv, 1'b0);

    // CPU word store
    s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_size = STORE_W;
    s_cpu_addr = 32'h40; s_cpu_wdata = 32'h12345678;
    step();
    chk("store_ram_we", obs_we, 1'b1);
    chk("store_ram_size", obs_sz, 3'b011);
    chk("store_ram_addr", obs_a, 32'h40);
    chk("store_ram_wdata", obs_w, 32'h12345678);
    idle_stim();
    step();
    chk("store_no_rvalid", obs_cv, 1'b0);

    // Reset in the cycle after a granted load
    s_cpu_req = 1'b1; s_cpu_addr = 32'h100;
    step();
    chk("rstmid_gnt", obs_cg, 1'b1);
    idle_stim();
    s_rst_n = 1'b0;
    step();
    chk("rstmid_rvalid_in_rst", obs_cv, 1'b0);
    s_rst_n = 1'b1;
    step();
    chk("rstmid_rvalid_after", {obs_cv, obs_dv}, 2'b00);
    chk("rstmid_ram_en", obs_en, 1'b0);

    // Randomized traffic with held requests and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (!s_cpu_req || obs_cg) begin
        s_cpu_req   = ($urandom_range(0, 99) < 60);
        s_cpu_we    = 1'($urandom_range(0, 1));
        s_cpu_size  = 3'($urandom_range(0, 3));
        s_cpu_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        s_cpu_wdata = $urandom;
      end
      if (!s_dma_req || obs_dg) begin
        s_dma_req   = ($urandom_range(0, 99) < 50);
        s_dma_we    = 1'($urandom_range(0, 1));
        s_dma_size  = 3'($urandom_range(0, 3));
        s_dma_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        s_dma_wdata = $urandom;
      end
      s_dma_lock = ($urandom_range(0, 3) != 0);
      s_rst_n    = ($urandom_range(0, 199) != 0);
      step();
    end
    idle_stim();
    s_rst_n = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-RAM arbiter between the CPU memory stage and a DMA/debug requester. Grants at most one access per cycle to the data RAM, routes registered read data back to the owner of the access, and raises a stall to the pipeline while the CPU is waiting. Sits between the memory stage and the data RAM instance, which has a synchronous read port with a 1-cycle latency.

## Interface
Parameters:
- XLEN, 32: data and address width.
- STARVE_MAX, 4: consecutive cycles a pending DMA request may lose to the CPU before DMA is forced (range 1..15).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with its fields stable until cpu_gnt.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  3  store-size code, using the shared store_flag encoding; ignored for loads.
- cpu_addr  in  XLEN  byte address.
- cpu_wdata  in  XLEN  store data.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  load data valid.
- cpu_rdata  out  XLEN  raw RAM word; extension is done in the memory stage.
- dma_req, dma_we, dma_size, dma_addr, dma_wdata  in  1/1/3/XLEN/XLEN  DMA request, with the same rules as the CPU request.
- dma_lock  in  1  when high together with a granted dma_req, DMA keeps ownership for back-to-back beats.
- dma_gnt  out  1  DMA request accepted.
- dma_rvalid  out  1  DMA load data valid.
- dma_rdata  out  XLEN  raw RAM word.
- ram_en  out  1  RAM access strobe; equals cpu_gnt | dma_gnt.
- ram_we  out  1  write strobe of the granted requester.
- ram_size  out  3  size code of the granted requester.
- ram_addr  out  XLEN  address of the granted requester.
- ram_wdata  out  XLEN  write data of the granted requester.
- ram_rdata  in  XLEN  RAM read data, valid the cycle after a load issue.

## Operation
- State machine has three states:
  - IDLE: no owner preference.
  - CPU_PRI: the CPU won the last contended cycle.
  - DMA_LOCKED: DMA holds a burst.
- Grant rules, evaluated combinationally each cycle:
  - Only one requester: it is granted.
  - Both requesting, state not DMA_LOCKED: the CPU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
  - DMA_LOCKED: DMA is granted if dma_req; the CPU is never granted.
- starve_cnt (4 bits):
  - Increments when dma_req & cpu_gnt.
  - Clears on dma_gnt or when ~dma_req.
  - Saturates at STARVE_MAX.
- Transitions:
  - Any state -> DMA_LOCKED on dma_gnt & dma_lock.
  - DMA_LOCKED -> IDLE when ~dma_lock or ~dma_req.
  - IDLE/CPU_PRI -> CPU_PRI on a contended CPU grant.
  - IDLE/CPU_PRI -> IDLE on a cycle with no request.
- Response tracking: on a granted load, register rsp_valid = 1 and rsp_owner = CPU/DMA.
  - Next cycle, assert the owner's rvalid with rdata = ram_rdata.
  - The other requester's rdata reads as 0.
- Stores produce no rvalid. The write completes in the grant cycle.
- ram_* outputs are 0 when nothing is granted.

## Timing
- Grant is combinational from the request in the same cycle. Load data arrives exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. A response in flight does not block a new issue.
- Reset values: cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_en and ram_we are 0; both rdata outputs are 0; state is IDLE; starve_cnt is 0; rsp_valid is 0.
- Reset asserted mid-access: the pending response is discarded. No rvalid appears in the cycle after reset deasserts.
- Simultaneous requests while starve_cnt == STARVE_MAX: DMA is granted and cpu_stall = 1 for that cycle.
- A request dropped before grant is a protocol violation. The block does not check for it, but it must not corrupt rsp_owner.

## Structure
- Shared config package: XLEN, the store-size codes (NO_STORE, store byte/half/word), and the owner tag constants (OWN_CPU = 0, OWN_DMA = 1).
- State encoding (2-bit) is local to the block.
- A separate response-pipe sub-module, `dmem_rsp_pipe`, holds rsp_valid/rsp_owner and demuxes rdata. The grant FSM stays in the top module.

## Test plan
- CPU only: load at 0x100 whose RAM word is 0xDEADBEEF -> cpu_gnt = 1 in cycle 0; cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF in cycle 1; cpu_stall = 0 throughout.
- Contention with STARVE_MAX = 4: CPU and DMA request continuously.
  - CPU is granted for 4 cycles, DMA on the 5th, and the pattern repeats.
  - cpu_stall = 1 only on the DMA-granted cycles.
- DMA burst: dma_lock = 1 for 3 load beats while cpu_req = 1.
  - dma_gnt for 3 consecutive cycles with cpu_stall = 1.
  - The CPU is granted in the cycle after dma_lock drops.
- Mixed response routing: CPU load at cycle 0, DMA load at cycle 1.
  - cpu_rvalid at cycle 1 and dma_rvalid at cycle 2, each carrying its own RAM word.
  - The other requester's rvalid is never asserted in those cycles.
- Store: CPU store of 0x12345678 with the word size code to 0x40 -> ram_we = 1 and ram_size = word code in the grant cycle; no cpu_rvalid follows.
- Reset mid-load: rst_n = 0 in the cycle after a granted load -> no rvalid afterwards; all outputs are 0 and state is IDLE after reset.
